vdp_vram_arbiter: RTL and testbench
===================================

# vdp_vram_arbiter

Single-port VRAM arbiter for the VDP. It shares one synchronous-read VRAM port between the raster-driven renderer fetch path and the host CPU. Renderer fetches get priority during the active frame, and host access is bounded-latency through an anti-starvation counter. During vertical blanking the host gets priority. Host writes are buffered in a small FIFO, and host reads are ordered behind all previously accepted writes.

## Interface
Parameters:
- ADDR_WIDTH, 14: VRAM word address width
- DATA_WIDTH, 16: VRAM word width
- FIFO_DEPTH_LOG2, 2: host write FIFO holds 2^FIFO_DEPTH_LOG2 entries
- STARVE_LIMIT, 8: maximum consecutive renderer grants while host work is pending; range 1..255

Ports:
- clk  in  1  sole clock
- reset_n  in  1  synchronous, active-low reset
- vblank  in  1  high outside the active frame (from the raster timing path)
- ren_req  in  1  renderer read request, may be held every cycle
- ren_addr  in  ADDR_WIDTH  renderer read address
- ren_grant  out  1  combinational; request accepted this cycle
- ren_rdata_valid  out  1  registered one-cycle pulse
- ren_rdata  out  DATA_WIDTH  registered read data
- host_wr_valid  in  1  host write offered
- host_wr_addr  in  ADDR_WIDTH  host write address
- host_wr_data  in  DATA_WIDTH  host write data
- host_wr_ready  out  1  combinational, equals !fifo_full
- host_rd_req  in  1  host read request pulse
- host_rd_addr  in  ADDR_WIDTH  host read address
- host_rd_busy  out  1  a read is pending or in flight
- host_rd_valid  out  1  registered one-cycle pulse
- host_rd_data  out  DATA_WIDTH  holds the last read result
- fifo_level  out  FIFO_DEPTH_LOG2+1  current FIFO occupancy
- vram_addr  out  ADDR_WIDTH  registered
- vram_we  out  1  registered
- vram_wdata  out  DATA_WIDTH  registered
- vram_rdata  in  DATA_WIDTH  valid in the cycle after the address is presented

## Operation
- **Slot allocation:** exactly one VRAM slot per cycle. It goes to the renderer, to the host, or stays idle.
- **Host work** means one of:
  - FIFO non-empty: the head write is served, in FIFO order.
  - Otherwise, a pending read.
- **Read ordering:** a pending read is never served while the FIFO is non-empty. This gives read-after-write ordering.
- **Priority when vblank=0:**
  - Renderer wins if ren_req=1.
  - Exception: host wins if host work exists and starve_count==STARVE_LIMIT.
- **Priority when vblank=1:** host wins if host work exists; otherwise the renderer is served.
- **Anti-starvation counter (starve_count, 8 bits):**
  - Increments when the renderer is granted while host work exists.
  - Clears when a host slot is granted, or in any cycle with no host work.
  - Saturates at STARVE_LIMIT.
- **Write FIFO:**
  - Push on host_wr_valid && host_wr_ready.
  - Pop when the host write slot is granted.
  - No bypass: when full, ready=0 even if a pop occurs in the same cycle.
  - An entry pushed in cycle N is eligible for a slot from N+1.
  - Push and pop in the same cycle leave the level unchanged.
- **Host read:**
  - host_rd_req is captured only when host_rd_busy=0; otherwise it is ignored.
  - Address is latched at capture; busy rises the next cycle.
  - Busy clears in the cycle host_rd_valid pulses.
- **Idle slot:** vram_we=0; vram_addr holds its previous value.

## Timing
- **Renderer read:**
  - Cycle N: ren_grant.
  - N+1: vram_addr=ren_addr, vram_we=0.
  - N+2: vram_rdata sampled.
  - N+3: ren_rdata_valid=1 with the data.
  - Throughput is one per cycle, fully pipelined.
- **Host read:** same pipeline; host_rd_valid pulses at N+3, where N is the grant cycle.
- **Host write:** slot granted in cycle N; vram_we=1 with address and data at N+1, for a single cycle.
- **Pipeline tagging:** a 2-bit source tag (none/ren/host) travels with each slot so read data is routed to exactly one consumer.
- **Reset (reset_n=0 at a clk edge):**
  - All outputs go to 0.
  - FIFO is emptied; the pending read and starve_count are cleared.
  - In-flight tags are cleared, so no valid pulse follows reset.
  - ren_grant and host_wr_ready are held at 0 while reset_n=0.
  - host_wr_ready=1 in the first cycle after release.
- **Host latency bound while vblank=0:** a host slot is granted within STARVE_LIMIT+1 cycles of host work appearing.

## Test plan
- **Reset:** hold reset_n=0 for 2 cycles with ren_req=1 and host_wr_valid=1 → ren_grant=0, vram_we=0, fifo_level=0. After release, host_wr_ready=1.
- **Write burst:** vblank=1, writes to 0x010..0x013 with data 0xA0..0xA3 offered back-to-back → first push cycle has level 1, ready=1. From the next cycle each push is balanced by a pop and the level stays at 1. vram_we pulses at 0x010..0x013 in order on consecutive cycles, one cycle after each grant. The level returns to 0 after the last write.
- **Starvation bound:** vblank=0, ren_req held, one host write pushed → exactly 8 consecutive ren_grants, then the host write on the 9th cycle, then renderer grants resume.
- **RAW ordering:** write 0x0042 to 0x100, then in the next cycle host_rd_req for 0x100 with vblank=1 → the write is issued first. host_rd_valid pulses with host_rd_data=0x0042, and host_rd_busy drops in the same cycle.
- **Renderer latency:** idle system, single ren_req for 0x0200 → ren_grant in the same cycle, vram_addr=0x0200 next cycle, ren_rdata_valid 3 cycles after the grant with the model data.
- **Reset mid-operation:** reset_n=0 in the cycle after a renderer grant, with 2 writes queued → no ren_rdata_valid afterwards, fifo_level=0, no vram_we.

Source files
------------

// File: rtl/vdp_vram_arbiter.sv
// rtl/vdp_vram_arbiter.sv - single-port VRAM arbiter between renderer fetch and host CPU
// Renderer has priority in the active frame and host has priority in vblank; host writes are queued ahead of reads.
module vdp_vram_arbiter #(
   parameter int ADDR_WIDTH      = 14,
   parameter int DATA_WIDTH      = 16,
   parameter int FIFO_DEPTH_LOG2 = 2,
   parameter int STARVE_LIMIT    = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       vblank,
   input  logic                       ren_req,
   input  logic [ADDR_WIDTH-1:0]      ren_addr,
   output logic                       ren_grant,
   output logic                       ren_rdata_valid,
   output logic [DATA_WIDTH-1:0]      ren_rdata,
   input  logic                       host_wr_valid,
   input  logic [ADDR_WIDTH-1:0]      host_wr_addr,
   input  logic [DATA_WIDTH-1:0]      host_wr_data,
   output logic                       host_wr_ready,
   input  logic                       host_rd_req,
   input  logic [ADDR_WIDTH-1:0]      host_rd_addr,
   output logic                       host_rd_busy,
   output logic                       host_rd_valid,
   output logic [DATA_WIDTH-1:0]      host_rd_data,
   output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
   output logic [ADDR_WIDTH-1:0]      vram_addr,
   output logic                       vram_we,
   output logic [DATA_WIDTH-1:0]      vram_wdata,
   input  logic [DATA_WIDTH-1:0]      vram_rdata
);

   localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;
   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_REN  = 2'd1,
      TAG_HOST = 2'd2
   } tag_t;

   logic [ADDR_WIDTH-1:0]      fifo_addr [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]      fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       push;
   logic                       pop;

   logic                       rd_pend;
   logic [ADDR_WIDTH-1:0]      rd_addr;
   logic                       rd_capture;
   logic [7:0]                 starve_count;

   logic                       host_work;
   logic                       host_sel;
   logic                       ren_sel;
   logic                       host_wr_sel;
   logic                       host_rd_sel;
   tag_t                       tag1;
   tag_t                       tag2;

   assign fifo_full   = (fifo_level == LVL_W'(FIFO_DEPTH));
   assign fifo_empty  = (fifo_level == '0);
   assign host_work   = !fifo_empty || rd_pend;
   assign host_wr_sel = host_sel && !fifo_empty;
   assign host_rd_sel = host_sel && fifo_empty;
   assign ren_grant   = ren_sel;

   // Ready ignores a same-cycle pop so the full flag never depends on the grant path.
   assign host_wr_ready = reset_n && !fifo_full;
   assign push          = host_wr_valid && host_wr_ready;
   assign pop           = host_wr_sel;
   assign rd_capture    = host_rd_req && !host_rd_busy;

   always_comb begin
      host_sel = 1'b0;
      ren_sel  = 1'b0;
      if (reset_n) begin
         if (vblank) begin
            host_sel = host_work;
            ren_sel  = !host_work && ren_req;
         end else begin
            ren_sel  = ren_req && !(host_work && (starve_count == STARVE_MAX));
            host_sel = host_work && !ren_sel;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= host_wr_addr;
         fifo_data[wr_ptr] <= host_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fifo_level      <= '0;
         starve_count    <= '0;
         rd_pend         <= 1'b0;
         rd_addr         <= '0;
         host_rd_busy    <= 1'b0;
         vram_addr       <= '0;
         vram_we         <= 1'b0;
         vram_wdata      <= '0;
         tag1            <= TAG_NONE;
         tag2            <= TAG_NONE;
         ren_rdata_valid <= 1'b0;
         ren_rdata       <= '0;
         host_rd_valid   <= 1'b0;
         host_rd_data    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
         if (pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LVL_W'(1);
            2'b01:   fifo_level <= fifo_level - LVL_W'(1);
            default: fifo_level <= fifo_level;
         endcase

         if (!host_work || host_sel)
            starve_count <= '0;
         else if (ren_sel && (starve_count != STARVE_MAX))
            starve_count <= starve_count + 8'd1;

         // Busy spans capture through the cycle the result is returned.
         if (tag2 == TAG_HOST) host_rd_busy <= 1'b0;
         if (rd_capture) begin
            rd_pend      <= 1'b1;
            rd_addr      <= host_rd_addr;
            host_rd_busy <= 1'b1;
         end else if (host_rd_sel) begin
            rd_pend <= 1'b0;
         end

         if (ren_sel) begin
            vram_addr <= ren_addr;
            vram_we   <= 1'b0;
            tag1      <= TAG_REN;
         end else if (host_wr_sel) begin
            vram_addr  <= fifo_addr[rd_ptr];
            vram_wdata <= fifo_data[rd_ptr];
            vram_we    <= 1'b1;
            tag1       <= TAG_NONE;
         end else if (host_rd_sel) begin
            vram_addr <= rd_addr;
            vram_we   <= 1'b0;
            tag1      <= TAG_HOST;
         end else begin
            vram_we <= 1'b0;
            tag1    <= TAG_NONE;
         end

         tag2            <= tag1;
         ren_rdata_valid <= (tag2 == TAG_REN);
         host_rd_valid   <= (tag2 == TAG_HOST);
         if (tag2 == TAG_REN)  ren_rdata    <= vram_rdata;
         if (tag2 == TAG_HOST) host_rd_data <= vram_rdata;
      end
   end

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// tb/tb_vdp_vram_arbiter.sv - scoreboard bench for vdp_vram_arbiter
// Stimulus queues expected VRAM writes and read returns; a negedge monitor pops and compares them.
module tb_vdp_vram_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        vblank;
   logic        ren_req;
   logic [13:0] ren_addr;
   logic        ren_grant;
   logic        ren_rdata_valid;
   logic [15:0] ren_rdata;
   logic        host_wr_valid;
   logic [13:0] host_wr_addr;
   logic [15:0] host_wr_data;
   logic        host_wr_ready;
   logic        host_rd_req;
   logic [13:0] host_rd_addr;
   logic        host_rd_busy;
   logic        host_rd_valid;
   logic [15:0] host_rd_data;
   logic [2:0]  fifo_level;
   logic [13:0] vram_addr;
   logic        vram_we;
   logic [15:0] vram_wdata;
   logic [15:0] vram_rdata;

   typedef struct {
      logic [13:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t         exp_wr[$];
   logic [15:0] exp_ren[$];
   logic [15:0] exp_hrd[$];
   logic [15:0] vmem [0:16383];
   int          checks = 0;
   int          failures = 0;
   logic        mon_en = 1'b0;

   always #5 clk = ~clk;

   vdp_vram_arbiter dut (
      .clk(clk), .reset_n(reset_n), .vblank(vblank),
      .ren_req(ren_req), .ren_addr(ren_addr), .ren_grant(ren_grant),
      .ren_rdata_valid(ren_rdata_valid), .ren_rdata(ren_rdata),
      .host_wr_valid(host_wr_valid), .host_wr_addr(host_wr_addr),
      .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
      .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr),
      .host_rd_busy(host_rd_busy), .host_rd_valid(host_rd_valid),
      .host_rd_data(host_rd_data), .fifo_level(fifo_level),
      .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
      .vram_rdata(vram_rdata)
   );

   function automatic logic [15:0] init_word(input logic [13:0] a);
      return {2'b00, a} ^ 16'h5A5A;
   endfunction

   // Synchronous-read VRAM: data for the presented address appears the next cycle.
   always @(posedge clk) begin
      if (vram_we) vmem[vram_addr] <= vram_wdata;
      vram_rdata <= vmem[vram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (vram_we) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", 32'(vram_we), 32'd0);
            else begin
               wr_t e;
               e = exp_wr.pop_front();
               chk("wr_addr", 32'(vram_addr), 32'(e.addr));
               chk("wr_data", 32'(vram_wdata), 32'(e.data));
            end
         end
         if (ren_rdata_valid) begin
            if (exp_ren.size() == 0) chk("ren_unexpected", 32'(ren_rdata_valid), 32'd0);
            else chk("ren_rdata", 32'(ren_rdata), 32'(exp_ren.pop_front()));
         end
         if (host_rd_valid) begin
            if (exp_hrd.size() == 0) chk("hrd_unexpected", 32'(host_rd_valid), 32'd0);
            else chk("host_rd_data", 32'(host_rd_data), 32'(exp_hrd.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ren_req       = 1'b0;
      host_wr_valid = 1'b0;
      host_rd_req   = 1'b0;
   endtask

   task automatic offer_wr(input logic [13:0] a, input logic [15:0] d);
      wr_t e;
      host_wr_valid = 1'b1;
      host_wr_addr  = a;
      host_wr_data  = d;
      e.addr = a;
      e.data = d;
      exp_wr.push_back(e);
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) vmem[i] = init_word(14'(i));
      reset_n = 1'b0;
      vblank = 1'b0;
      ren_req = 1'b1;
      ren_addr = 14'h0;
      host_wr_valid = 1'b1;
      host_wr_addr = 14'h7;
      host_wr_data = 16'h7;
      host_rd_req = 1'b0;
      host_rd_addr = 14'h0;
      #1;

      // Reset held for two cycles with requests asserted
      @(negedge clk);
      chk("rst0_ren_grant", 32'(ren_grant), 32'd0);
      chk("rst0_wr_ready", 32'(host_wr_ready), 32'd0);
      tick();
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst1_ren_grant", 32'(ren_grant), 32'd0);
      chk("rst1_vram_we", 32'(vram_we), 32'd0);
      chk("rst1_fifo_level", 32'(fifo_level), 32'd0);
      chk("rst1_ren_valid", 32'(ren_rdata_valid), 32'd0);
      tick();
      reset_n = 1'b1;
      idle_inputs();
      @(negedge clk);
      chk("post_rst_wr_ready", 32'(host_wr_ready), 32'd1);
      tick();
      repeat (2) tick();

      // Renderer latency from an idle system
      ren_req = 1'b1;
      ren_addr = 14'h0200;
      exp_ren.push_back(init_word(14'h0200));
      @(negedge clk);
      chk("lat_grant", 32'(ren_grant), 32'd1);
      tick();
      idle_inputs();
      @(negedge clk);
      chk("lat_vram_addr", 32'(vram_addr), 32'h0200);
      chk("lat_vram_we", 32'(vram_we), 32'd0);
      tick();
      @(negedge clk);
      chk("lat_valid_n2", 32'(ren_rdata_valid), 32'd0);
      tick();
      @(negedge clk);
      chk("lat_valid_n3", 32'(ren_rdata_valid), 32'd1);
      tick();
      repeat (3) tick();

      // Back-to-back write burst during vblank
      vblank = 1'b1;
      for (int i = 0; i < 4; i++) begin
         offer_wr(14'h010 + 14'(i), 16'h00A0 + 16'(i));
         @(negedge clk);
         chk("burst_ready", 32'(host_wr_ready), 32'd1);
         chk("burst_level", 32'(fifo_level), (i == 0) ? 32'd0 : 32'd1);
         chk("burst_we", 32'(vram_we), (i >= 2) ? 32'd1 : 32'd0);
         tick();
      end
      idle_inputs();
      @(negedge clk);
      chk("burst_level_b4", 32'(fifo_level), 32'd1);
      chk("burst_we_b4", 32'(vram_we), 32'd1);
      tick();
      @(negedge clk);
      chk("burst_level_b5", 32'(fifo_level), 32'd0);
      chk("burst_we_b5", 32'(vram_we), 32'd1);
      tick();
      @(negedge clk);
      chk("burst_we_b6", 32'(vram_we), 32'd0);
      tick();
      repeat (2) tick();

      // Anti-starvation: renderer held, one host write
      vblank = 1'b0;
      ren_req = 1'b1;
      ren_addr = 14'h0400;
      offer_wr(14'h0500, 16'h1234);
      exp_ren.push_back(init_word(14'h0400));
      @(negedge clk);
      chk("starve_c0_grant", 32'(ren_grant), 32'd1);
      tick();
      host_wr_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (k != 9) exp_ren.push_back(init_word(14'h0400));
         @(negedge clk);
         chk($sformatf("starve_c%0d_grant", k), 32'(ren_grant), (k == 9) ? 32'd0 : 32'd1);
         chk($sformatf("starve_c%0d_we", k), 32'(vram_we), (k == 10) ? 32'd1 : 32'd0);
         tick();
      end
      idle_inputs();
      repeat (5) tick();

      // Read-after-write ordering during vblank
      vblank = 1'b1;
      offer_wr(14'h0100, 16'h0042);
      tick();
      host_wr_valid = 1'b0;
      host_rd_req = 1'b1;
      host_rd_addr = 14'h0100;
      exp_hrd.push_back(16'h0042);
      @(negedge clk);
      chk("raw_busy_r1", 32'(host_rd_busy), 32'd0);
      tick();
      idle_inputs();
      @(negedge clk);
      chk("raw_busy_r2", 32'(host_rd_busy), 32'd1);
      chk("raw_we_r2", 32'(vram_we), 32'd1);
      chk("raw_addr_r2", 32'(vram_addr), 32'h0100);
      tick();
      @(negedge clk);
      chk("raw_we_r3", 32'(vram_we), 32'd0);
      chk("raw_addr_r3", 32'(vram_addr), 32'h0100);
      tick();
      @(negedge clk);
      chk("raw_valid_r4", 32'(host_rd_valid), 32'd0);
      chk("raw_busy_r4", 32'(host_rd_busy), 32'd1);
      tick();
      @(negedge clk);
      chk("raw_valid_r5", 32'(host_rd_valid), 32'd1);
      chk("raw_busy_r5", 32'(host_rd_busy), 32'd0);
      tick();
      @(negedge clk);
      chk("raw_valid_r6", 32'(host_rd_valid), 32'd0);
      chk("raw_hold_r6", 32'(host_rd_data), 32'h0042);
      tick();
      repeat (2) tick();

      // Reset in the middle of renderer traffic with two queued writes
      vblank = 1'b0;
      ren_req = 1'b1;
      ren_addr = 14'h0600;
      host_wr_valid = 1'b1;
      host_wr_addr = 14'h0700;
      host_wr_data = 16'h1111;
      @(negedge clk);
      chk("mid_m0_grant", 32'(ren_grant), 32'd1);
      tick();
      host_wr_addr = 14'h0701;
      host_wr_data = 16'h2222;
      @(negedge clk);
      chk("mid_m1_grant", 32'(ren_grant), 32'd1);
      tick();
      host_wr_valid = 1'b0;
      reset_n = 1'b0;
      exp_wr.delete();
      exp_ren.delete();
      exp_hrd.delete();
      @(negedge clk);
      chk("mid_m2_level", 32'(fifo_level), 32'd2);
      chk("mid_m2_grant", 32'(ren_grant), 32'd0);
      tick();
      reset_n = 1'b1;
      idle_inputs();
      for (int k = 3; k <= 8; k++) begin
         @(negedge clk);
         chk($sformatf("mid_m%0d_level", k), 32'(fifo_level), 32'd0);
         chk($sformatf("mid_m%0d_ren_valid", k), 32'(ren_rdata_valid), 32'd0);
         chk($sformatf("mid_m%0d_we", k), 32'(vram_we), 32'd0);
         tick();
      end

      chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
      chk("ren_queue_drained", 32'(exp_ren.size()), 32'd0);
      chk("hrd_queue_drained", 32'(exp_hrd.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
